// File: rtl/absdiff_pkg.sv
// Shared types for the iterative absolute-difference unit (absdiff_iter).
package absdiff_pkg;

  // Controller states: accept, bit-serial compare, subtract, hold result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } absdiff_state_t;

endpackage

// File: rtl/absdiff_iter_gtcell.sv
// One bit of a greater-than comparator chain. din marks that a more significant
// bit already differed; gt fires only on the first (most significant) differing
// bit when in0 has the 1.
module GTComparator_1b_GL (
  input  logic in0,
  input  logic in1,
  input  logic din,
  output logic dout,
  output logic gt
);

  assign dout = din | (in0 ^ in1);
  assign gt   = ~din & in0 & ~in1;

endmodule

// File: rtl/absdiff_iter.sv
// Iterative |in0 - in1| unit. Walks the operands MSB-first through a single
// 1-bit GT cell, then subtracts the smaller operand from the larger.
// Optional build macro: ABSDIFF_ITER_EARLY_EXIT_EN -- leave the compare phase
// as soon as the first differing bit has been seen.
module absdiff_iter
  import absdiff_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_val,
  output logic         in_rdy,
  input  logic [N-1:0] in0,
  input  logic [N-1:0] in1,
  output logic         out_val,
  input  logic         out_rdy,
  output logic [N-1:0] out,
  output logic         gt
);

  localparam int IDX_W = $clog2(N);

  absdiff_state_t state, state_next;

  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic [IDX_W-1:0] idx;
  logic             done;
  logic             gtr;

  logic cell_dout;
  logic cell_gt;

  GTComparator_1b_GL u_cell (
    .in0  (a[idx]),
    .in1  (b[idx]),
    .din  (done),
    .dout (cell_dout),
    .gt   (cell_gt)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_val) begin
          state_next = CMP;
        end
      end
      CMP: begin
`ifdef ABSDIFF_ITER_EARLY_EXIT_EN
        // Once a bit differs, gtr is final and the remaining bits add nothing.
        if ((cell_dout == 1'b1) || (idx == '0)) begin
          state_next = SUB;
        end
`else
        if (idx == '0) begin
          state_next = SUB;
        end
`endif
      end
      SUB: begin
        state_next = DONE;
      end
      DONE: begin
        if (out_rdy) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake outputs, decoded from state only.
  always_comb begin
    in_rdy  = (state == IDLE);
    out_val = (state == DONE);
  end

  // Datapath: operand capture, bit-serial compare accumulation, subtract.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a    <= '0;
      b    <= '0;
      idx  <= '0;
      done <= 1'b0;
      gtr  <= 1'b0;
      out  <= '0;
      gt   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_val) begin
            a    <= in0;
            b    <= in1;
            idx  <= IDX_W'(N - 1);
            done <= 1'b0;
            gtr  <= 1'b0;
          end
        end
        CMP: begin
          done <= cell_dout;
          gtr  <= gtr | cell_gt;
          idx  <= idx - 1'b1;
        end
        SUB: begin
          // Plain ternary so an unknown gtr propagates into out.
          out <= gtr ? (a - b) : (b - a);
          gt  <= gtr;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_absdiff_iter.sv
// Self-checking bench for absdiff_iter (N=8): directed table, reset and
// back-pressure sequences, and randomized operands against a plain-arithmetic model.
module tb_absdiff_iter;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         in_val;
  logic         in_rdy;
  logic [N-1:0] in0;
  logic [N-1:0] in1;
  logic         out_val;
  logic         out_rdy;
  logic [N-1:0] out;
  logic         gt;

  int n_cmp = 0;
  int n_bad = 0;
  time prev_acc = 0;
  int  prev_lat = 0;

  absdiff_iter #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in0     (in0),
    .in1     (in1),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out     (out),
    .gt      (gt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] exp_out;
    logic         exp_gt;
    int           hold;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: unsigned magnitude and ordering from plain arithmetic.
  function automatic logic [N-1:0] model_out(input logic [N-1:0] x, input logic [N-1:0] y);
    int d;
    d = int'(x) - int'(y);
    if (d < 0) d = -d;
    return N'(d);
  endfunction

  function automatic logic model_gt(input logic [N-1:0] x, input logic [N-1:0] y);
    return (int'(x) > int'(y));
  endfunction

  // Posedges from accept edge until the edge that first sees out_val high.
  function automatic int model_lat(input logic [N-1:0] x, input logic [N-1:0] y);
    int lat;
    lat = N + 2;
`ifdef ABSDIFF_ITER_EARLY_EXIT_EN
    if (x != y) begin
      for (int i = 0; i < N; i++) begin
        if (x[i] != y[i]) lat = (N - i) + 2;
      end
    end
`endif
    return lat;
  endfunction

  // One full transaction; called at a negedge, returns at a negedge with the
  // result consumed. hold = DONE cycles with out_rdy low; early = out_rdy high
  // before the result appears; gap = also check the spacing from the last accept.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] eo, input logic eg,
                        input int hold, input bit early, input bit gap,
                        input string nm);
    int t;
    int cnt;
    int exp_lat;
    time acc;
    logic [N-1:0] so;
    logic sg;
    exp_lat = model_lat(a, b);
    out_rdy = early;
    t = 0;
    while (!in_rdy && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_in_rdy"}, 32'(in_rdy), 32'd1);
    in_val = 1'b1;
    in0 = a;
    in1 = b;
    @(posedge clk);
    acc = $time;
    if (gap) chk({nm, "_gap"}, 32'((acc - prev_acc) / 10), 32'(prev_lat + 1));
    prev_acc = acc;
    prev_lat = exp_lat;
    @(negedge clk);
    in_val = 1'b0;
    in0 = N'($urandom);
    in1 = N'($urandom);
    cnt = 0;
    while (!out_val && cnt < 3 * N + 10) begin
      chk({nm, "_busy_rdy"}, 32'(in_rdy), 32'd0);
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    chk({nm, "_lat"}, 32'(cnt + 1), 32'(exp_lat));
    chk({nm, "_out"}, 32'(out), 32'(eo));
    chk({nm, "_gt"}, 32'(gt), 32'(eg));
    so = out;
    sg = gt;
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_hold_val"}, 32'(out_val), 32'd1);
        chk({nm, "_hold_out"}, 32'(out), 32'(so));
        chk({nm, "_hold_gt"}, 32'(gt), 32'(sg));
        chk({nm, "_hold_rdy"}, 32'(in_rdy), 32'd0);
      end
    end
    out_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_post_val"}, 32'(out_val), 32'd0);
    chk({nm, "_post_rdy"}, 32'(in_rdy), 32'd1);
    out_rdy = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    vecs[0] = '{a: 8'd200,  b: 8'd55,   exp_out: 8'd145, exp_gt: 1'b1, hold: 5};
    vecs[1] = '{a: 8'd3,    b: 8'd250,  exp_out: 8'd247, exp_gt: 1'b0, hold: 0};
    vecs[2] = '{a: 8'h3C,   b: 8'h3C,   exp_out: 8'd0,   exp_gt: 1'b0, hold: 2};
    vecs[3] = '{a: 8'h80,   b: 8'h00,   exp_out: 8'd128, exp_gt: 1'b1, hold: 0};
    vecs[4] = '{a: 8'd0,    b: 8'd255,  exp_out: 8'd255, exp_gt: 1'b0, hold: 1};
    vecs[5] = '{a: 8'd1,    b: 8'd0,    exp_out: 8'd1,   exp_gt: 1'b1, hold: 0};

    rst = 1'b1;
    in_val = 1'b0;
    out_rdy = 1'b0;
    in0 = '0;
    in1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_val", 32'(out_val), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_gt", 32'(gt), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_rdy", 32'(in_rdy), 32'd1);

    // Directed table.
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp_out, vecs[i].exp_gt,
             vecs[i].hold, 1'b0, 1'b0, $sformatf("tbl%0d", i));
    end

    // Back-to-back pair with out_rdy already high in DONE.
    run_op(8'd200, 8'd55, 8'd145, 1'b1, 0, 1'b1, 1'b0, "b2b0");
    run_op(8'd3, 8'd250, 8'd247, 1'b0, 0, 1'b1, 1'b1, "b2b1");

    // Asynchronous reset mid-cycle while a result is being held.
    @(negedge clk);
    in_val = 1'b1;
    in0 = 8'd200;
    in1 = 8'd55;
    @(posedge clk);
    @(negedge clk);
    in_val = 1'b0;
    seen = 0;
    while (!out_val && seen < 3 * N + 10) begin
      @(negedge clk);
      seen++;
    end
    chk("arst_pre_val", 32'(out_val), 32'd1);
    chk("arst_pre_out", 32'(out), 32'd145);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_val", 32'(out_val), 32'd0);
    chk("arst_out", 32'(out), 32'd0);
    chk("arst_gt", 32'(gt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_in_rdy", 32'(in_rdy), 32'd1);

    // Reset pulse during the compare phase drops the operation.
    @(negedge clk);
    in_val = 1'b1;
    in0 = 8'd9;
    in1 = 8'd4;
    @(posedge clk);
    @(negedge clk);
    in_val = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    seen = 0;
    repeat (N + 4) begin
      @(negedge clk);
      if (out_val) seen = 1;
    end
    chk("cmp_rst_no_val", 32'(seen), 32'd0);
    run_op(8'd4, 8'd9, 8'd5, 1'b0, 0, 1'b0, 1'b0, "after_rst");

    // Randomized operands against the arithmetic model.
    for (int k = 0; k < 40; k++) begin
      ra = N'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? ra : N'($urandom);
      run_op(ra, rb, model_out(ra, rb), model_gt(ra, rb),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0,
             $sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
